// File: rtl/bf8_irq_pkg.sv
// rtl/bf8_irq_pkg.sv - shared BrainForge8 interrupt definitions
// States, interrupt identifiers and the maskable/non-maskable split.
package bf8_irq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PUSH_H = 3'd1,
    PUSH_L = 3'd2,
    PUSH_F = 3'd3,
    VEC_L  = 3'd4,
    VEC_H  = 3'd5,
    LOAD   = 3'd6
  } irq_state_e;

  localparam logic [3:0] ID_IRQ      = 4'd0;
  localparam logic [3:0] ID_RESET    = 4'd8;
  localparam logic [3:0] ID_DMA_DONE = 4'd9;
  localparam logic [3:0] ID_DMA_ERR  = 4'd10;
  localparam logic [3:0] ID_STK_OVF  = 4'd11;
  localparam logic [3:0] ID_STK_UNF  = 4'd12;

  localparam logic [3:0] MASKABLE_MAX = 4'd7;

  function automatic logic is_maskable(input logic [3:0] id);
    return id <= MASKABLE_MAX;
  endfunction

endpackage

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt entry sequencer for the BrainForge8 core
// Pushes PC/FLAGS, fetches the handler vector, loads PC and acknowledges.
module irq_sequencer
  import bf8_irq_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE = 16'hFFE0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  NEXT_ID,
  input  logic        NEXT_ON,
  input  logic        RESET_ON,
  output logic        ACK,
  input  logic        IE,
  input  logic        CPU_IDLE,
  output logic        BUSY,
  input  logic [15:0] PC,
  input  logic [7:0]  FLAGS,
  output logic        STACK_PUSH,
  output logic [7:0]  STACK_DATA,
  input  logic        STACK_RDY,
  input  logic        STACK_ERR,
  output logic        MEM_REQ,
  output logic [15:0] MEM_ADDR,
  input  logic        MEM_RDY,
  input  logic [7:0]  MEM_RDATA,
  output logic        PC_LOAD,
  output logic [15:0] PC_NEW,
  output logic        IE_CLR,
  output logic        FAULT
);

  irq_state_e  state_q, state_d;
  logic [3:0]  id_q, id_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  flags_q, flags_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] pc_new_q, pc_new_d;
  logic        fault_q, fault_d;
  logic        accept;
  logic [15:0] vec_addr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      id_q     <= 4'd0;
      pc_q     <= 16'd0;
      flags_q  <= 8'd0;
      lo_q     <= 8'd0;
      pc_new_q <= 16'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      lo_q     <= lo_d;
      pc_new_q <= pc_new_d;
      fault_q  <= fault_d;
    end
  end

  // fault_q blocks acceptance: the controller only drops NEXT_ON after the fault ACK
  assign accept = NEXT_ON && !RESET_ON && CPU_IDLE && !fault_q &&
                  (IE || !is_maskable(NEXT_ID));

  assign vec_addr = VECTOR_BASE + {11'd0, id_q, 1'b0};

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    lo_d     = lo_q;
    pc_new_d = pc_new_q;
    fault_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = NEXT_ID;
          pc_d    = PC;
          flags_d = FLAGS;
          state_d = (NEXT_ID == ID_RESET) ? VEC_L : PUSH_H;
        end
      end
      PUSH_H, PUSH_L, PUSH_F: begin
        if (RESET_ON) begin
          state_d = IDLE;
        end else if (STACK_ERR) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end else if (STACK_RDY) begin
          case (state_q)
            PUSH_H:  state_d = PUSH_L;
            PUSH_L:  state_d = PUSH_F;
            default: state_d = VEC_L;
          endcase
        end
      end
      VEC_L: begin
        if (RESET_ON) begin
          state_d = IDLE;
        end else if (MEM_RDY) begin
          lo_d    = MEM_RDATA;
          state_d = VEC_H;
        end
      end
      VEC_H: begin
        if (RESET_ON) begin
          state_d = IDLE;
        end else if (MEM_RDY) begin
          pc_new_d = {MEM_RDATA, lo_q};
          state_d  = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY       = (state_q != IDLE);
    STACK_PUSH = 1'b0;
    STACK_DATA = 8'd0;
    MEM_REQ    = 1'b0;
    MEM_ADDR   = 16'd0;
    case (state_q)
      PUSH_H: begin
        STACK_PUSH = 1'b1;
        STACK_DATA = pc_q[15:8];
      end
      PUSH_L: begin
        STACK_PUSH = 1'b1;
        STACK_DATA = pc_q[7:0];
      end
      PUSH_F: begin
        STACK_PUSH = 1'b1;
        STACK_DATA = flags_q;
      end
      VEC_L: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = vec_addr;
      end
      VEC_H: begin
        MEM_REQ  = 1'b1;
        MEM_ADDR = vec_addr + 16'd1;
      end
      default: ;
    endcase
  end

  assign PC_LOAD = (state_q == LOAD);
  assign IE_CLR  = (state_q == LOAD);
  assign ACK     = (state_q == LOAD) || fault_q;
  assign FAULT   = fault_q;
  assign PC_NEW  = pc_new_q;

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Downstream consumer of the interrupt controller's pending-interrupt outputs for the BrainForge8 core. When an interrupt is pending and the CPU reaches an instruction boundary, the block:

- pushes PC and FLAGS through the stack unit,
- fetches the 16-bit handler vector from the vector table,
- loads it into the PC and acknowledges the controller.

Reset (ID 8) skips the stack pushes.

## Interface
Parameters:
- VECTOR_BASE, 16'hFFE0: byte address of vector table; 16 entries × 2 bytes, little-endian.

Ports (reset RST, asynchronous, active-low; clock CLK):
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- NEXT_ID  in  4  pending interrupt identifier
- NEXT_ON  in  1  interrupt pending
- RESET_ON  in  1  controller in reset mode; sequencer held idle
- ACK  out  1  one-cycle acknowledge to controller
- IE  in  1  global interrupt enable (CPU flag)
- CPU_IDLE  in  1  CPU at instruction boundary, safe to preempt
- BUSY  out  1  sequence in progress; CPU must stall
- PC  in  16  current program counter
- FLAGS  in  8  current flags register
- STACK_PUSH  out  1  push request
- STACK_DATA  out  8  byte to push
- STACK_RDY  in  1  push accepted this cycle
- STACK_ERR  in  1  push refused (overflow)
- MEM_REQ  out  1  vector read request
- MEM_ADDR  out  16  vector read address
- MEM_RDY  in  1  read data valid this cycle
- MEM_RDATA  in  8  read data
- PC_LOAD  out  1  one-cycle PC write strobe
- PC_NEW  out  16  handler address
- IE_CLR  out  1  one-cycle strobe clearing IE
- FAULT  out  1  one-cycle pulse on aborted sequence

## Operation
States: IDLE, PUSH_H, PUSH_L, PUSH_F, VEC_L, VEC_H, LOAD.

**IDLE**
- Accepts when NEXT_ON=1, RESET_ON=0, CPU_IDLE=1, and (IE=1 or NEXT_ID≥8).
- IDs 0–7 are maskable. IDs 8–15 are non-maskable.
- On acceptance, latches ID, PC and FLAGS.
- ID 8 goes to VEC_L; all other IDs go to PUSH_H.

**Push states**
- PUSH_H / PUSH_L / PUSH_F: STACK_PUSH=1 with STACK_DATA = PC[15:8], then PC[7:0], then FLAGS (latched copies).
- Each state advances when STACK_RDY=1.

**Vector fetch**
- VEC_L: MEM_REQ=1, MEM_ADDR = VECTOR_BASE + {ID,1'b0}; captures MEM_RDATA as low byte when MEM_RDY=1.
- VEC_H: MEM_ADDR is that address + 1; captures the high byte.
- Address arithmetic is 16-bit modulo; 16'hFFFF + 1 wraps to 16'h0000.

**LOAD**
- Single cycle: PC_LOAD=1, PC_NEW={hi,lo}, IE_CLR=1, ACK=1, then IDLE.
- PC_NEW holds its value until the next LOAD.

**Request hold rules**
- Each request (STACK_PUSH, MEM_REQ) and its data/address stay stable until the matching RDY is sampled high.
- RDY in the same cycle as the request is legal (zero wait).

**Stack fault**
- STACK_ERR=1 in any PUSH state takes priority over STACK_RDY.
- Response: FAULT pulse, ACK pulse (interrupt consumed), no PC_LOAD, no IE_CLR, then IDLE.

**RESET_ON mid-sequence**
- RESET_ON=1 in any non-IDLE state aborts to IDLE.
- All strobes stay low, no ACK, no FAULT.

**IDs**
- IDs 13–15 are sequenced like any other non-maskable ID.

## Timing
Reset values (async RST low):
- State IDLE.
- BUSY, ACK, STACK_PUSH, MEM_REQ, PC_LOAD, IE_CLR, FAULT all 0.
- STACK_DATA, MEM_ADDR, PC_NEW are 0.

Strobe behaviour:
- All outputs are registered or decoded from the state register only; no combinational paths from inputs.
- BUSY=1 in every state except IDLE, starting the cycle after acceptance.
- ACK, PC_LOAD and IE_CLR are high for exactly the one LOAD cycle.
- The controller clears NEXT_ON on that edge, so IDLE never re-accepts the same interrupt.

Latency with zero-wait stack and memory, acceptance edge to PC_LOAD cycle:
- Non-reset IDs: 6 cycles.
- ID 8: 3 cycles.
- Each wait cycle on STACK_RDY or MEM_RDY adds exactly 1.

Sampling rules:
- NEXT_ID and NEXT_ON are sampled only in IDLE; changes during a sequence are ignored.
- IE is sampled only at acceptance.

## Structure
- Shared package `bf8_irq_pkg`:
  - state enum;
  - interrupt ID constants: ID_IRQ=0, ID_RESET=8, ID_DMA_DONE=9, ID_DMA_ERR=10, ID_STK_OVF=11, ID_STK_UNF=12;
  - MASKABLE_MAX=7.
- Controller and sequencer both import it.
- Single module; no sub-module warranted.

## Test plan
- **Reset path:** RESET_ON falls with NEXT_ID=8, NEXT_ON=1, VECTOR_BASE=16'hFFE0, memory returns 34h @FFF0 and 12h @FFF1 → no STACK_PUSH; PC_NEW=16'h1234 with PC_LOAD+ACK 3 cycles after acceptance.
- **Maskable IRQ:** ID 3, IE=1, PC=16'hABCD, FLAGS=5Ah → pushes AB, CD, 5A in order; reads FFE6/FFE7; LOAD with IE_CLR=1 at cycle 6.
- **Masking:** ID 2 with IE=0 → stays IDLE indefinitely, no ACK. Raising NEXT_ID to 9 with IE=0 → accepted.
- **Wait states:** STACK_RDY delayed 2 cycles on PUSH_L, MEM_RDY delayed 3 cycles on VEC_H → STACK_DATA/MEM_ADDR held stable throughout; PC_LOAD at cycle 11.
- **Stack fault:** STACK_ERR during PUSH_L → FAULT and ACK pulse together for one cycle; no PC_LOAD or IE_CLR; back to IDLE.
- **Aborts and wrap:** RESET_ON raised in VEC_L → IDLE next cycle, no ACK. Async RST low in PUSH_F → all outputs 0 immediately. VECTOR_BASE=16'hFFFE with ID 15 → reads at 001C and 001D.
